// File: rtl/bsg_nonsynth_manycore_print_stat_tracker.sv
// bsg_nonsynth_manycore_print_stat_tracker: pairs kernel START/END print_stat events per tag slot and queues elapsed-cycle records
// Ports: clk_i / reset_n_i clock and async active-low reset; en_i gates the cycle counter and event intake;
//   print_stat_v_i / print_stat_tag_i incoming event stream ([31:30] type, [29:16] tg_id, low bits slot);
//   v_o / tag_o / tg_id_o / elapsed_o / yumi_i head of the record FIFO; active_o per-slot open START;
//   overflow_o sticky record drop; err_cnt_o saturating protocol error count.
module bsg_nonsynth_manycore_print_stat_tracker #(
    parameter int data_width_p = 32,
    parameter int num_tags_p   = 16,
    parameter int ctr_width_p  = 32,
    parameter int fifo_els_p   = 4,
    parameter int err_width_p  = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          en_i,
    input  logic                          print_stat_v_i,
    input  logic [data_width_p-1:0]       print_stat_tag_i,
    output logic                          v_o,
    output logic [$clog2(num_tags_p)-1:0] tag_o,
    output logic [13:0]                   tg_id_o,
    output logic [ctr_width_p-1:0]        elapsed_o,
    input  logic                          yumi_i,
    output logic [num_tags_p-1:0]         active_o,
    output logic                          overflow_o,
    output logic [err_width_p-1:0]        err_cnt_o
);
    localparam int tag_w_lp = $clog2(num_tags_p);
    localparam int rec_w_lp = tag_w_lp + 14 + ctr_width_p;
    localparam int ptr_w_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int cnt_w_lp = $clog2(fifo_els_p + 1);

    logic [ctr_width_p-1:0] ctr_r;
    logic [ctr_width_p-1:0] start_r [num_tags_p];
    logic [rec_w_lp-1:0]    mem_r [fifo_els_p];
    logic [num_tags_p-1:0]  active_n;
    logic [ptr_w_lp-1:0]    rd_ptr_r, wr_ptr_r;
    logic [cnt_w_lp-1:0]    cnt_r;
    logic [1:0]             ev_type;
    logic [13:0]            ev_tg_id;
    logic [tag_w_lp-1:0]    ev_slot;
    logic ev_v, is_start, is_end, is_rsvd, slot_active, hit_end, full, push, pop, drop, err_inc;
    logic unused_tag_bits;

    assign ev_type         = print_stat_tag_i[data_width_p-1 -: 2];
    assign ev_tg_id        = print_stat_tag_i[data_width_p-3 -: 14];
    assign ev_slot         = print_stat_tag_i[tag_w_lp-1:0];
    assign unused_tag_bits = ^print_stat_tag_i[data_width_p-17:tag_w_lp];

    assign ev_v        = en_i & print_stat_v_i;
    assign is_start    = ev_v & (ev_type == 2'b01);
    assign is_end      = ev_v & (ev_type == 2'b10);
    assign is_rsvd     = ev_v & (ev_type == 2'b11);
    assign slot_active = active_o[ev_slot];
    assign hit_end     = is_end & slot_active;
    assign err_inc     = is_rsvd | (is_start & slot_active) | (is_end & ~slot_active);

    // A full FIFO still accepts a record when the head is taken the same cycle.
    assign full = cnt_r == cnt_w_lp'(fifo_els_p);
    assign v_o  = cnt_r != '0;
    assign pop  = yumi_i & v_o;
    assign push = hit_end & (~full | pop);
    assign drop = hit_end & ~push;
    assign {tag_o, tg_id_o, elapsed_o} = mem_r[rd_ptr_r];

    // END clears the slot even when its record is dropped.
    always_comb begin
        active_n = active_o;
        if (is_start) active_n[ev_slot] = 1'b1;
        if (is_end) active_n[ev_slot] = 1'b0;
    end

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(fifo_els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ctr_r      <= '0;
            active_o   <= '0;
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            cnt_r      <= '0;
            overflow_o <= 1'b0;
            err_cnt_o  <= '0;
        end else begin
            if (en_i) ctr_r <= ctr_r + ctr_width_p'(1);
            active_o <= active_n;
            if (push) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (pop) rd_ptr_r <= ptr_inc(rd_ptr_r);
            cnt_r <= cnt_r + cnt_w_lp'(push) - cnt_w_lp'(pop);
            if (drop) overflow_o <= 1'b1;
            if (err_inc && err_cnt_o != '1) err_cnt_o <= err_cnt_o + err_width_p'(1);
        end
    end

    // Timestamps and record storage need no reset; validity lives in active_o and cnt_r.
    // Modular subtraction keeps elapsed correct across counter wrap.
    always_ff @(posedge clk_i) begin
        if (is_start) start_r[ev_slot] <= ctr_r;
        if (push) mem_r[wr_ptr_r] <= {ev_slot, ev_tg_id, ctr_r - start_r[ev_slot]};
    end
endmodule

// File: tb/tb_bsg_nonsynth_manycore_print_stat_tracker.sv
// tb_bsg_nonsynth_manycore_print_stat_tracker: directed self-checking bench for the print_stat tracker
module tb_bsg_nonsynth_manycore_print_stat_tracker;
    localparam logic [1:0] STAT = 2'b00, START = 2'b01, END_T = 2'b10, RSVD = 2'b11;

    logic        clk = 1'b0, reset_n = 1'b0, en = 1'b0, pv = 1'b0, yumi = 1'b0;
    logic [31:0] tag = '0;
    logic        v, overflow;
    logic [3:0]  tag_o;
    logic [13:0] tg_id;
    logic [7:0]  elapsed, err;
    logic [15:0] active;
    int tests = 0, fails = 0;

    bsg_nonsynth_manycore_print_stat_tracker #(.ctr_width_p(8)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .en_i(en),
        .print_stat_v_i(pv), .print_stat_tag_i(tag),
        .v_o(v), .tag_o(tag_o), .tg_id_o(tg_id), .elapsed_o(elapsed), .yumi_i(yumi),
        .active_o(active), .overflow_o(overflow), .err_cnt_o(err)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [1:0] ty, input logic [13:0] id, input logic [3:0] slot);
        tag = {ty, id, 12'b0, slot};
        pv = 1'b1;
        cyc(1);
        pv = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic chk_rec(input string name, input logic [3:0] t, input logic [13:0] id, input logic [7:0] el);
        chk({name, ".v"}, v, 1);
        chk({name, ".tag"}, tag_o, t);
        chk({name, ".tg_id"}, tg_id, id);
        chk({name, ".elapsed"}, elapsed, el);
        if (v) begin
            yumi = 1'b1;
            cyc(1);
            yumi = 1'b0;
        end
    endtask

    initial begin
        cyc(3);
        reset_n = 1'b1;
        en = 1'b1;
        chk("rst.v", v, 0);
        chk("rst.active", active, 0);
        chk("rst.overflow", overflow, 0);
        chk("rst.err", err, 0);

        // basic pair: START at ctr=10, END at ctr=110
        cyc(10);
        send(START, 14'd0, 4'd3);
        chk("t1.active_set", active, 16'h0008);
        chk("t1.no_rec", v, 0);
        cyc(99);
        send(END_T, 14'd5, 4'd3);
        chk("t1.active_clr", active, 0);
        chk_rec("t1", 4'd3, 14'd5, 8'd100);
        chk("t1.empty", v, 0);

        // counter at 112; advance to 252 and straddle the 8-bit wrap
        cyc(140);
        send(START, 14'd0, 4'd0);
        cyc(7);
        send(END_T, 14'd9, 4'd0);
        chk_rec("t2.wrap", 4'd0, 14'd9, 8'd8);

        // END without START, then double START
        send(END_T, 14'd1, 4'd7);
        chk("t3.no_rec", v, 0);
        chk("t3.err1", err, 1);
        send(START, 14'd0, 4'd7);
        cyc(3);
        send(START, 14'd0, 4'd7);
        chk("t3.err2", err, 2);
        chk("t3.active", active, 16'h0080);
        cyc(4);
        send(END_T, 14'd2, 4'd7);
        chk_rec("t3.restart", 4'd7, 14'd2, 8'd5);

        // fill the FIFO, push with simultaneous pop, then drop
        for (int i = 0; i < 4; i++) begin
            send(START, 14'd0, 4'(i));
            send(END_T, 14'(100 + i), 4'(i));
        end
        chk("t4.full_v", v, 1);
        chk("t4.no_ovf", overflow, 0);
        send(START, 14'd0, 4'd4);
        yumi = 1'b1;
        send(END_T, 14'd104, 4'd4);
        yumi = 1'b0;
        chk("t4.pop_push_ovf", overflow, 0);
        send(START, 14'd0, 4'd5);
        send(END_T, 14'd105, 4'd5);
        chk("t4.drop_ovf", overflow, 1);
        chk("t4.drop_active", active, 0);
        for (int i = 1; i < 5; i++) chk_rec("t4.rec", 4'(i), 14'(100 + i), 8'd1);
        chk("t4.empty", v, 0);
        chk("t4.ovf_sticky", overflow, 1);

        // STAT / reserved types and en_i=0 behaviour
        send(START, 14'd0, 4'd9);
        send(STAT, 14'd0, 4'd8);
        chk("t5.stat_err", err, 2);
        send(RSVD, 14'd0, 4'd8);
        chk("t5.rsvd_err", err, 3);
        en = 1'b0;
        send(END_T, 14'd0, 4'd9);
        chk("t5.dis_end_active", active, 16'h0200);
        chk("t5.dis_end_v", v, 0);
        send(RSVD, 14'd0, 4'd8);
        send(START, 14'd0, 4'd12);
        chk("t5.dis_err", err, 3);
        chk("t5.dis_start", active, 16'h0200);
        cyc(5);
        en = 1'b1;
        send(END_T, 14'd33, 4'd9);
        chk_rec("t5.frozen", 4'd9, 14'd33, 8'd3);

        // async reset with a full FIFO, overflow and an open slot
        for (int i = 0; i < 5; i++) begin
            send(START, 14'd0, 4'(i));
            send(END_T, 14'd7, 4'(i));
        end
        send(START, 14'd0, 4'd10);
        chk("t6.pre_v", v, 1);
        chk("t6.pre_ovf", overflow, 1);
        chk("t6.pre_active", active, 16'h0400);
        #2 reset_n = 1'b0;
        #1;
        chk("t6.async_v", v, 0);
        chk("t6.async_active", active, 0);
        chk("t6.async_ovf", overflow, 0);
        chk("t6.async_err", err, 0);
        cyc(2);
        reset_n = 1'b1;
        cyc(3);
        chk("t6.post_v", v, 0);
        chk("t6.post_active", active, 0);
        send(START, 14'd0, 4'd2);
        send(END_T, 14'd44, 4'd2);
        chk_rec("t6.post_rec", 4'd2, 14'd44, 8'd1);

        // saturating error counter
        tag = {RSVD, 30'd0};
        pv = 1'b1;
        cyc(254);
        chk("sat.254", err, 254);
        cyc(2);
        pv = 1'b0;
        chk("sat.255", err, 255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
